// File: rtl/reg_serializer_if.sv
// Handshake bundle between a word producer and reg_serializer.
// The master side loads words and consumes the LSB-first bit stream.
interface reg_serializer_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             sout_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load, data_in, sout_ready,
    input  sout, sout_valid, busy, done
  );

  modport slave (
    input  load, data_in, sout_ready,
    output sout, sout_valid, busy, done
  );
endinterface

// File: rtl/reg_serializer.sv
// Captures a WIDTH-bit word on load and streams it out LSB-first over a
// valid/ready serial link, pulsing done for one cycle after the last bit.
module reg_serializer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            clr,
  reg_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Declaration initialisers give the cleared state at power-up without clr.
  state_t           state_q = IDLE;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q = '0;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    cnt_q   = '0;
  logic [CW-1:0]    cnt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops at LAST rather than wrapping; DONE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sout_ready) begin
          shift_d = shift_q >> 1;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout       = bus.sout_valid ? shift_q[0] : 1'b0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer at WIDTH=32 and WIDTH=8; expected bits
// are queued when a word is loaded and popped as each handshake completes.
module tb_reg_serializer;

  logic clk = 1'b0;
  logic clr;
  int   tests  = 0;
  int   failed = 0;
  int   done32 = 0;
  int   done8  = 0;
  logic q32[$];
  logic q8[$];

  reg_serializer_if #(.WIDTH(32)) bus32();
  reg_serializer_if #(.WIDTH(8))  bus8();

  reg_serializer #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(bus32));
  reg_serializer #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit narrow, input logic [31:0] word);
    if (narrow) begin
      bus8.load    = 1'b1;
      bus8.data_in = word[7:0];
      for (int i = 0; i < 8; i++) q8.push_back(word[i]);
    end else begin
      bus32.load    = 1'b1;
      bus32.data_in = word;
      for (int i = 0; i < 32; i++) q32.push_back(word[i]);
    end
  endtask

  task automatic waitDone(input bit narrow, input int startCyc, output int cyc);
    cyc = startCyc;
    while (((narrow ? bus8.done : bus32.done) !== 1'b1) && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  // Scoreboard: each presented bit must match the queue head; a handshake pops it.
  always @(negedge clk) begin
    if (bus32.done === 1'b1) done32++;
    if (clr !== 1'b1) begin
      if (bus32.sout_valid === 1'b1) begin
        checkOutput("w32 bit pending", 64'(q32.size() != 0), 64'(1));
        if (q32.size() != 0) begin
          checkOutput("w32 sout", bus32.sout, q32[0]);
          if (bus32.sout_ready === 1'b1) void'(q32.pop_front());
        end
      end else begin
        checkOutput("w32 sout idle", bus32.sout, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.done === 1'b1) done8++;
    if (clr !== 1'b1) begin
      if (bus8.sout_valid === 1'b1) begin
        checkOutput("w8 bit pending", 64'(q8.size() != 0), 64'(1));
        if (q8.size() != 0) begin
          checkOutput("w8 sout", bus8.sout, q8[0]);
          if (bus8.sout_ready === 1'b1) void'(q8.pop_front());
        end
      end else begin
        checkOutput("w8 sout idle", bus8.sout, 0);
      end
    end
  end

  initial begin
    int cyc;
    int d0;
    clr              = 1'b0;
    bus32.load       = 1'b0;
    bus32.data_in    = '0;
    bus32.sout_ready = 1'b1;
    bus8.load        = 1'b0;
    bus8.data_in     = '0;
    bus8.sout_ready  = 1'b1;
    #1;
    checkOutput("powerup busy", bus32.busy, 0);
    checkOutput("powerup valid", bus32.sout_valid, 0);
    checkOutput("powerup sout", bus32.sout, 0);
    checkOutput("powerup done", bus32.done, 0);
    checkOutput("powerup busy8", bus8.busy, 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("reset busy", bus32.busy, 0);
    checkOutput("reset valid", bus32.sout_valid, 0);
    checkOutput("reset done", bus32.done, 0);

    // Full word with ready held high
    applyStimulus(1'b0, 32'hA5A50F0F);
    tick();
    bus32.load = 1'b0;
    checkOutput("a5 first valid", bus32.sout_valid, 1);
    checkOutput("a5 first bit", bus32.sout, 1);
    checkOutput("a5 busy", bus32.busy, 1);
    waitDone(1'b0, 1, cyc);
    checkOutput("a5 done cycle", cyc, 33);
    checkOutput("a5 valid in done", bus32.sout_valid, 0);
    tick();
    checkOutput("a5 busy after", bus32.busy, 0);
    checkOutput("a5 done after", bus32.done, 0);
    checkOutput("a5 done count", done32, 1);

    // Five-cycle stall while bit 3 is presented
    applyStimulus(1'b0, 32'hA5A50F0F);
    tick();
    bus32.load = 1'b0;
    cyc = 1;
    repeat (3) begin
      tick();
      cyc++;
    end
    checkOutput("stall bit3", bus32.sout, 1);
    bus32.sout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cyc++;
      checkOutput("stall hold valid", bus32.sout_valid, 1);
      checkOutput("stall hold bit", bus32.sout, 1);
    end
    bus32.sout_ready = 1'b1;
    waitDone(1'b0, cyc, cyc);
    checkOutput("stall done cycle", cyc, 38);
    tick();

    // Load while busy must be ignored
    applyStimulus(1'b0, 32'h00000000);
    tick();
    bus32.load = 1'b0;
    cyc = 1;
    repeat (9) begin
      tick();
      cyc++;
    end
    bus32.load    = 1'b1;
    bus32.data_in = 32'hFFFFFFFF;
    tick();
    cyc++;
    bus32.load = 1'b0;
    checkOutput("ignored load busy", bus32.busy, 1);
    waitDone(1'b0, cyc, cyc);
    checkOutput("ignored load done cycle", cyc, 33);
    tick();
    checkOutput("ignored load idle", bus32.busy, 0);

    // Abort after 12 handshakes
    d0 = done32;
    applyStimulus(1'b0, 32'hDEADBEEF);
    tick();
    bus32.load = 1'b0;
    repeat (12) tick();
    checkOutput("abort bits left", q32.size(), 20);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q32.delete();
    checkOutput("abort valid", bus32.sout_valid, 0);
    checkOutput("abort busy", bus32.busy, 0);
    checkOutput("abort done", bus32.done, 0);
    checkOutput("abort sout", bus32.sout, 0);
    repeat (3) tick();
    checkOutput("abort no done", done32, d0);
    applyStimulus(1'b0, 32'h00000001);
    tick();
    bus32.load = 1'b0;
    checkOutput("post abort first bit", bus32.sout, 1);
    waitDone(1'b0, 1, cyc);
    checkOutput("post abort done cycle", cyc, 33);
    tick();

    // clr beats load on the same edge
    clr           = 1'b1;
    bus32.load    = 1'b1;
    bus32.data_in = 32'hFFFFFFFF;
    tick();
    clr        = 1'b0;
    bus32.load = 1'b0;
    checkOutput("clr vs load busy", bus32.busy, 0);
    checkOutput("clr vs load valid", bus32.sout_valid, 0);
    tick();
    checkOutput("clr vs load still idle", bus32.busy, 0);

    // WIDTH=8 back-to-back words with load held high
    d0 = done8;
    applyStimulus(1'b1, 32'h81);
    tick();
    applyStimulus(1'b1, 32'h7E);
    waitDone(1'b1, 1, cyc);
    checkOutput("w8 first done cycle", cyc, 9);
    tick();
    checkOutput("w8 gap busy", bus8.busy, 0);
    checkOutput("w8 gap valid", bus8.sout_valid, 0);
    tick();
    bus8.load = 1'b0;
    checkOutput("w8 second valid", bus8.sout_valid, 1);
    checkOutput("w8 second first bit", bus8.sout, 0);
    waitDone(1'b1, 1, cyc);
    checkOutput("w8 second done cycle", cyc, 9);
    tick();
    checkOutput("w8 done count", done8, d0 + 2);

    checkOutput("w32 queue drained", q32.size(), 0);
    checkOutput("w8 queue drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, number of bits in the captured word (legal 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: clr  input  1  reset, synchronous, active-high; sampled only on posedge clk.
REQ-004 SHALL have port: load  input  1  request to capture data_in and start serial readout.
REQ-005 SHALL have port: data_in  input  WIDTH  parallel word to read out.
REQ-006 SHALL have port: sout_ready  input  1  downstream accepts current bit this cycle.
REQ-007 SHALL have port: sout  output  1  current serial bit, LSB-first.
REQ-008 SHALL have port: sout_valid  output  1  sout holds a valid bit.
REQ-009 SHALL have port: busy  output  1  word in flight; load ignored.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after last bit accepted.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-012 SHALL, in IDLE with load=1 at edge k, capture data_in into shift register, clear bit counter to 0, enter SHIFT; sout_valid=1 and sout=data_in[0] in cycle k+1.
REQ-013 SHALL ignore load in SHIFT and DONE; data_in changes while busy do not affect output.
REQ-014 SHALL, in SHIFT, count a handshake only when sout_valid=1 and sout_ready=1 at a posedge; the shift register then shifts right one bit and the counter increments.
REQ-015 SHALL hold sout, sout_valid and the counter unchanged on any SHIFT cycle with sout_ready=0 (arbitrary stall length).
REQ-016 SHALL present bit i of the captured word on sout after exactly i handshakes (i = 0..WIDTH-1).
REQ-017 SHALL, on the handshake with counter = WIDTH-1, enter DONE; sout_valid=0 in DONE.
REQ-018 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-019 SHALL accept a new load in the first IDLE cycle after DONE (minimum word-to-word gap: WIDTH+2 cycles with sout_ready tied 1).
REQ-020 SHALL use a counter of ceil(log2(WIDTH)) bits; counter never exceeds WIDTH-1 and never wraps.
REQ-021 SHALL drive sout=0 whenever sout_valid=0.
REQ-022 SHALL give clr priority over load and sout_ready on the same edge.

Reset
REQ-023 SHALL, on posedge clk with clr=1, set state=IDLE, shift register=0, counter=0; outputs next cycle: sout=0, sout_valid=0, busy=0, done=0.
REQ-024 SHALL, when clr=1 mid-SHIFT or in DONE, abandon the word with no done pulse; bits already accepted are not retracted.
REQ-025 SHALL power up in the REQ-023 state without requiring clr (initial values), matching existing register cells.

Verification
REQ-026 SHALL cover: WIDTH=32, load data_in=0xA5A50F0F, sout_ready=1 -> bits 1,1,1,1,0,0,0,0,... (LSB-first) in cycles 1..32 after load edge, done=1 in cycle 33, busy=0 in cycle 34.
REQ-027 SHALL cover: sout_ready=0 for 5 cycles after bit 3 is presented -> sout holds bit 3 for 6 cycles, total readout 37 cycles, same bit sequence.
REQ-028 SHALL cover: load with data_in=0xFFFFFFFF issued in cycle 10 of a 0x00000000 readout -> ignored, all 32 output bits 0.
REQ-029 SHALL cover: clr=1 after 12 handshakes -> next cycle sout_valid=0, busy=0, done never asserts; subsequent load of 0x1 -> sout=1 first, then 31 zeros.
REQ-030 SHALL cover: WIDTH=8, back-to-back loads of 0x81 then 0x7E (second load asserted continuously) -> second word starts in first IDLE cycle after done; sequences 1,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,0.
REQ-031 SHALL cover: load=1 and clr=1 on same edge -> remains IDLE, sout_valid=0.
